// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        INIT = 2'b00,
        IDLE = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } dmem_state_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the MEM stage and the data memory controller.
interface data_memory_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        fault;
    logic        busy;

    modport master (
        output req_valid, MemRead, MemWrite, MemtoReg, size, is_unsigned,
               address, write_data,
        input  req_ready, resp_valid, read_data, fault, busy
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, MemtoReg, size, is_unsigned,
               address, write_data,
        output req_ready, resp_valid, read_data, fault, busy
    );

endinterface

// File: rtl/data_memory_ctrl_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension, misalign check.
module dmem_lane_align
    import mips_mem_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    input  logic        unsigned_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    assign shifted = rword_i >> {lane_i, 3'b000};

    always_comb begin
        be_o       = '0;
        wdata_o    = wdata_i;
        rdata_o    = '0;
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o       = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = unsigned_i ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
                misalign_o = lane_i[0];
            end
            SZ_WORD: begin
                be_o       = 4'b1111;
                rdata_o    = rword_i;
                misalign_o = (lane_i != 2'b00);
            end
            default: begin
                be_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: post-reset clear sweep, valid/ready handshake with wait states,
// sized loads/stores with fault detection, and MemtoReg response selection.
module data_memory_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter int unsigned WAIT_STATES    = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
)(
    input  logic           clk,
    input  logic           rst,
    data_memory_ctrl_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [31:0]   mem_q [DEPTH_WORDS];

    dmem_state_e   state_q;
    logic [AW-1:0] init_idx_q;
    logic [3:0]    wait_cnt_q;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic [31:0]   read_data_q;
    logic          fault_q;
    logic          busy_q;
    logic [31:0]   pend_data_q;
    logic          pend_fault_q;

    mem_size_e     sz;
    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic [3:0]    be;
    logic [31:0]   st_data;
    logic [31:0]   ld_aligned;
    logic          misalign;
    logic          accept;
    logic          access;
    logic          flt;
    logic [31:0]   load_val;
    logic [31:0]   resp_data;
    logic          mem_we;
    logic          init_we;

    assign sz           = mem_size_e'(bus.size);
    assign word_idx     = bus.address[AW+1:2];
    assign out_of_range = (bus.address >> (AW + 2)) != '0;

    dmem_lane_align u_align (
        .size_i     (sz),
        .lane_i     (bus.address[1:0]),
        .wdata_i    (bus.write_data),
        .rword_i    (mem_q[word_idx]),
        .unsigned_i (bus.is_unsigned),
        .be_o       (be),
        .wdata_o    (st_data),
        .rdata_o    (ld_aligned),
        .misalign_o (misalign)
    );

    // Alignment/range only matter when the array is touched; a reserved size always faults.
    assign accept    = (state_q == IDLE) && req_ready_q && bus.req_valid;
    assign access    = bus.MemRead || bus.MemWrite;
    assign flt       = (sz == SZ_RSVD) || (access && (misalign || out_of_range));
    assign load_val  = (bus.MemRead && !flt) ? ld_aligned : '0;
    assign resp_data = bus.MemtoReg ? load_val : bus.address;
    assign mem_we    = accept && bus.MemWrite && !flt && !rst;
    assign init_we   = (state_q == INIT) && !rst;

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_idx_q] <= '0;
        end else if (mem_we) begin
            for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) mem_q[word_idx][b*8 +: 8] <= st_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? INIT : IDLE;
            init_idx_q   <= '0;
            wait_cnt_q   <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            read_data_q  <= '0;
            fault_q      <= 1'b0;
            busy_q       <= CLEAR_ON_RESET;
            pend_data_q  <= '0;
            pend_fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q  <= 1'b0;
                        pend_data_q  <= resp_data;
                        pend_fault_q <= flt;
                        wait_cnt_q   <= '0;
                        if (WAIT_STATES == 0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            read_data_q  <= resp_data;
                            fault_q      <= flt;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        read_data_q  <= pend_data_q;
                        fault_q      <= pend_fault_q;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    fault_q      <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.read_data  = read_data_q;
    assign bus.fault      = fault_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed vector bench for data_memory_ctrl (DEPTH 256, one wait state, clear on reset).
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    data_memory_ctrl_if bus ();

    data_memory_ctrl #(
        .DEPTH_WORDS    (DEPTH),
        .WAIT_STATES    (WS),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        m2r;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        flt;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    task automatic idle_bus();
        bus.req_valid   = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.size        = 2'b10;
        bus.is_unsigned = 1'b0;
        bus.address     = '0;
        bus.write_data  = '0;
    endtask

    // Pulses rst for one cycle, then checks reset values and the INIT duration.
    task automatic do_reset(input logic hold_valid);
        int cyc;
        logic ready_seen;
        logic resp_seen;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_read_data", bus.read_data, 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);
        bus.req_valid = hold_valid;
        cyc = 0;
        ready_seen = 1'b0;
        resp_seen = 1'b0;
        while (bus.busy === 1'b1 && cyc < 2000) begin
            cyc++;
            if (bus.req_ready !== 1'b0) ready_seen = 1'b1;
            if (bus.resp_valid !== 1'b0) resp_seen = 1'b1;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        check("init_cycles", 32'(cyc), 32'(DEPTH));
        check("init_ready_low", 32'(ready_seen), 32'd0);
        check("init_no_resp", 32'(resp_seen), 32'd0);
        check("post_init_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // Issues one request when ready and returns response data/fault and latency.
    task automatic do_req(input vec_t v, output logic [31:0] data, output logic flt,
                          output int lat);
        int guard;
        guard = 0;
        data = 'x;
        flt = 1'bx;
        lat = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (bus.req_ready !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL req_ready_timeout: ready=%b, want 1", bus.req_ready);
            return;
        end
        bus.req_valid   = 1'b1;
        bus.MemRead     = v.rd;
        bus.MemWrite    = v.wr;
        bus.MemtoReg    = v.m2r;
        bus.size        = v.sz;
        bus.is_unsigned = v.uns;
        bus.address     = v.addr;
        bus.write_data  = v.wdata;
        @(posedge clk); #1;
        idle_bus();
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        data = bus.read_data;
        flt  = bus.fault;
        @(posedge clk); #1;
    endtask

    logic [31:0] d;
    logic        f;
    int          lat;
    vec_t        tmp;

    initial begin
        idle_bus();
        //           rd wr m2r sz    uns addr          wdata         exp           flt
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h80FF_7F01, 32'h0000_0010, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_007F, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_00FF, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0020, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 32'h0000_0022, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_3344, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_BEEF, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'hCAFE_F00D, 32'h0000_000C, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_000E, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'hAAAA_5555, 32'h0000_0030, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h1234_5678, 32'hAAAA_5555, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h0,         32'h1234_5678, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,         32'h0000_0030, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0040, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'h0,         32'h0000_0041, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0,         32'h0000_0000, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'h0000_77A5, 32'h0000_0023, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hA5EF_3344, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_03FF, 32'h0,         32'h0000_0000, 1'b0};

        @(posedge clk); #1;
        do_reset(1'b0);

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i], d, f, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(WS + 1));
            check($sformatf("v%0d_data", i), d, vecs[i].exp);
            check($sformatf("v%0d_fault", i), 32'(f), 32'(vecs[i].flt));
        end

        // Store then abort a load with reset during its wait state.
        tmp = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h1111_2222, 32'h0, 1'b0};
        do_req(tmp, d, f, lat);
        tmp = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0050, 32'h0, 32'h0, 1'b0};
        bus.req_valid = 1'b1;
        bus.MemRead   = 1'b1;
        bus.MemtoReg  = 1'b1;
        bus.address   = 32'h50;
        @(posedge clk); #1;
        idle_bus();
        check("abort_in_wait_no_resp", 32'(bus.resp_valid), 32'd0);
        do_reset(1'b1);

        do_req(tmp, d, f, lat);
        check("post_abort_latency", 32'(lat), 32'(WS + 1));
        check("post_abort_cleared", d, 32'h0);
        check("post_abort_fault", 32'(f), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
